// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, one-word-per-cycle imem handshake, one-entry stall buffer, branch redirect/flush.
// Optional `define IF_PERF_COUNT_EN adds fetchCount/stallCount performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemRead,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] programCounterOut,
    output logic [31:0] instruction,
`ifdef IF_PERF_COUNT_EN
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount,
`endif
    output logic        instructionValid
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] hold_buf_r, hold_buf_s;
    logic [31:0] pending_r, pending_s;
    logic [31:0] addr_r, addr_s;
    logic        read_r, read_s;
    logic [31:0] pc_out_r, pc_out_s;
    logic [31:0] instr_r, instr_s;
    logic        valid_r, valid_s;
    logic [31:0] target_s;

    assign target_s = branchTarget & 32'hFFFF_FFFC;

    // Next-state and next-output decode; branch redirect always wins over stall.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        hold_buf_s = hold_buf_r;
        pending_s  = pending_r;
        pc_out_s   = pc_out_r;
        instr_s    = instr_r;
        valid_s    = valid_r;
        case (state_r)
            ST_FETCH: begin
                if (branchTaken) begin
                    instr_s = NOP_WORD;
                    valid_s = 1'b0;
                    if (imemReady) begin
                        pc_s = target_s;
                    end else begin
                        pending_s = target_s;
                        state_s   = ST_DISCARD;
                    end
                end else if (imemReady) begin
                    pc_s = pc_r + 32'd4;
                    if (!stall) begin
                        instr_s  = imemData;
                        pc_out_s = pc_r + 32'd4;
                        valid_s  = 1'b1;
                    end else begin
                        hold_buf_s = imemData;
                        state_s    = ST_HOLD;
                    end
                end else if (!stall) begin
                    instr_s = NOP_WORD;
                    valid_s = 1'b0;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (branchTaken) begin
                    instr_s = NOP_WORD;
                    valid_s = 1'b0;
                    pc_s    = target_s;
                    state_s = ST_FETCH;
                end else if (!stall) begin
                    // pc already advanced past the buffered word, so it is that word's PC+4
                    instr_s  = hold_buf_r;
                    pc_out_s = pc_r;
                    valid_s  = 1'b1;
                    state_s  = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (branchTaken) begin
                    instr_s   = NOP_WORD;
                    valid_s   = 1'b0;
                    pending_s = target_s;
                    if (imemReady) begin
                        pc_s    = target_s;
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end else begin
                    if (imemReady) begin
                        pc_s    = pending_r;
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                    if (!stall) begin
                        instr_s = NOP_WORD;
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                end
            end
            default: begin
                state_s = ST_FETCH;
                pc_s    = RESET_VECTOR;
                instr_s = NOP_WORD;
                valid_s = 1'b0;
            end
        endcase
        read_s = (state_s != ST_HOLD);
        // The request address stays parked while a word sits in the hold buffer.
        if (state_s == ST_HOLD) begin
            addr_s = addr_r;
        end else begin
            addr_s = pc_s;
        end
    end

    // Fetch state, PC and registered decode-side outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_VECTOR;
            hold_buf_r <= NOP_WORD;
            pending_r  <= RESET_VECTOR;
            addr_r     <= RESET_VECTOR;
            read_r     <= 1'b0;
            pc_out_r   <= 32'd0;
            instr_r    <= NOP_WORD;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            hold_buf_r <= hold_buf_s;
            pending_r  <= pending_s;
            addr_r     <= addr_s;
            read_r     <= read_s;
            pc_out_r   <= pc_out_s;
            instr_r    <= instr_s;
            valid_r    <= valid_s;
        end
    end

    assign imemRead          = read_r;
    assign imemAddr          = addr_r;
    assign programCounterOut = pc_out_r;
    assign instruction       = instr_r;
    assign instructionValid  = valid_r;

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        fetch_inc_s;

    // A fresh delivery only happens on an unstalled, unredirected cycle that produces a valid word.
    assign fetch_inc_s = valid_s && !stall && !branchTaken;

    // Wrapping performance counters.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            fetch_cnt_r <= fetch_inc_s ? fetch_cnt_r + 32'd1 : fetch_cnt_r;
            stall_cnt_r <= stall ? stall_cnt_r + 32'd1 : stall_cnt_r;
        end
    end

    assign fetchCount = fetch_cnt_r;
    assign stallCount = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random traffic,
// checked every cycle against a word-queue model of the fetch stage.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetN;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemRead;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] programCounterOut;
    logic [31:0] instruction;
    logic        instructionValid;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    int checks = 0;
    int errors = 0;

    // Model: requested address, next fetch pointer, optional buffered word, pending redirect.
    logic [31:0] m_addr, m_fptr, m_pend, m_buf_addr, m_instr, m_pcout;
    logic        m_read, m_buf, m_drop, m_valid;
    logic [31:0] m_fetch, m_stall;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk               (clk),
        .resetN            (resetN),
        .stall             (stall),
        .branchTaken       (branchTaken),
        .branchTarget      (branchTarget),
        .imemRead          (imemRead),
        .imemAddr          (imemAddr),
        .imemReady         (imemReady),
        .imemData          (imemData),
        .programCounterOut (programCounterOut),
        .instruction       (instruction),
`ifdef IF_PERF_COUNT_EN
        .fetchCount        (fetchCount),
        .stallCount        (stallCount),
`endif
        .instructionValid  (instructionValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 32'd0; m_fptr = 32'd0; m_pend = 32'd0; m_buf_addr = 32'd0;
        m_instr = NOP; m_pcout = 32'd0; m_read = 1'b0; m_buf = 1'b0;
        m_drop = 1'b0; m_valid = 1'b0; m_fetch = 32'd0; m_stall = 32'd0;
    endtask

    task automatic m_deliver(input logic [31:0] a);
        m_instr = a;                 // memory returns its own address as data
        m_pcout = a + 32'd4;
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd1;
    endtask

    task automatic m_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        logic [31:0] t;
        logic        acc;
        t   = tgt & 32'hFFFF_FFFC;
        acc = m_read && rdy;
        if (st) m_stall = m_stall + 32'd1;
        if (br) begin
            m_buf = 1'b0;
            m_bubble();
            if (acc || !m_read) begin
                m_fptr = t;
                m_drop = 1'b0;
            end else begin
                m_drop = 1'b1;
                m_pend = t;
            end
        end else if (m_drop) begin
            if (acc) begin
                m_drop = 1'b0;
                m_fptr = m_pend;
            end
            if (!st) m_bubble();
        end else if (!st) begin
            if (m_buf) begin
                m_deliver(m_buf_addr);
                m_buf = 1'b0;
            end else if (acc) begin
                m_deliver(m_addr);
                m_fptr = m_addr + 32'd4;
            end else begin
                m_bubble();
            end
        end else if (acc) begin
            m_buf      = 1'b1;
            m_buf_addr = m_addr;
            m_fptr     = m_addr + 32'd4;
        end
        m_read = !m_buf;
        if (!m_buf) m_addr = m_fptr;
    endtask

    task automatic check_all();
        chk("instruction", instruction, m_instr);
        chk("instructionValid", {31'd0, instructionValid}, {31'd0, m_valid});
        chk("programCounterOut", programCounterOut, m_pcout);
        chk("imemRead", {31'd0, imemRead}, {31'd0, m_read});
        chk("imemAddr", imemAddr, m_addr);
`ifdef IF_PERF_COUNT_EN
        chk("fetchCount", fetchCount, m_fetch);
        chk("stallCount", stallCount, m_stall);
`endif
    endtask

    task automatic cyc(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        logic r;
        r            = rdy && m_read;
        stall        = st;
        branchTaken  = br;
        branchTarget = tgt;
        imemReady    = r;
        imemData     = imemAddr;
        @(posedge clk);
        model_edge(st, br, tgt, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; stall = 1'b0; branchTaken = 1'b0;
        branchTarget = 32'd0; imemReady = 1'b0; imemData = 32'd0;
        do_reset();

        // Zero-wait memory: bubble on first edge, then 0,4,8,C back to back.
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("zw_last_word", instruction, 32'h0000_000C);
        chk("zw_last_pc4", programCounterOut, 32'h0000_0010);

        // Memory wait states at 0x10.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        chk("wait_addr_stable", imemAddr, 32'h0000_0010);
        chk("wait_bubble", {31'd0, instructionValid}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wait_word", instruction, 32'h0000_0010);
        chk("wait_pc4", programCounterOut, 32'h0000_0014);

        // Stall while the 0x20 response arrives.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        chk("hold_read_low", {31'd0, imemRead}, 32'd0);
        chk("hold_frozen", instruction, 32'h0000_001C);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("hold_addr", imemAddr, 32'h0000_0020);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("hold_release_word", instruction, 32'h0000_0020);
        chk("hold_next_addr", imemAddr, 32'h0000_0024);

        // Redirect with the 0x40 fetch outstanding.
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        chk("br_bubble", {31'd0, instructionValid}, 32'd0);
        chk("br_old_addr", imemAddr, 32'h0000_0040);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("br_dropped", {31'd0, instructionValid}, 32'd0);
        chk("br_target_addr", imemAddr, 32'h0000_0100);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("br_target_word", instruction, 32'h0000_0100);

        // Redirect during a stall with a word buffered, then PC wrap.
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("hold_br_bubble", {31'd0, instructionValid}, 32'd0);
        chk("hold_br_addr", imemAddr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc4", programCounterOut, 32'h0000_0000);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_word", instruction, 32'h0000_0000);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5,
                $urandom, $urandom_range(99, 0) < 60);

        // Reset in the middle of a discarded fetch.
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        do_reset();
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst_restart_word", instruction, 32'h0000_0000);
        chk("rst_restart_pc4", programCounterOut, 32'h0000_0004);

        // Counter scenario: 3 stall cycles, 10 deliveries.
        do_reset();
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
`ifdef IF_PERF_COUNT_EN
        chk("fetch_count_10", fetchCount, 32'd10);
        chk("stall_count_3", stallCount, 32'd3);
`endif
        do_reset();
`ifdef IF_PERF_COUNT_EN
        chk("fetch_count_rst", fetchCount, 32'd0);
        chk("stall_count_rst", stallCount, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front pipeline stage of the single-issue 32-bit microprocessor. Holds the program counter, fetches one instruction word per cycle from instruction memory over a ready-handshake, and registers `{programCounterOut, instruction, instructionValid}` into the decode stage. Honours decode-side stall, and takes branch redirects from later stages by flushing the delivered slot and discarding any in-flight fetch.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset
- `NOP_WORD`, 32'h0000_0000, instruction word driven for bubbles/flushes
- `clk`  in  1  single clock, all state on rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `stall`  in  1  decode cannot accept; fetch outputs must hold
- `branchTaken`  in  1  redirect request, single-cycle pulse
- `branchTarget`  in  32  redirect address; bits [1:0] forced to 0
- `imemRead`  out  1  fetch request
- `imemAddr`  out  32  fetch address, word-aligned
- `imemReady`  in  1  response valid this cycle (same cycle as `imemData`)
- `imemData`  in  32  fetched word
- `programCounterOut`  out  32  PC+4 of delivered instruction
- `instruction`  out  32  delivered instruction word
- `instructionValid`  out  1  1 = real instruction, 0 = bubble
- `fetchCount`, `stallCount`  out  32 each  only with `IF_PERF_COUNT_EN`

## Operation
- States: FETCH, HOLD, DISCARD. Registers: `pc`, `holdBuf`, `pendingTarget`.
- FETCH: `imemRead`=1, `imemAddr`=`pc`. Address held stable until `imemReady` sampled high.
  - `imemReady` & !`stall`: deliver `imemData`, `programCounterOut`<=`pc`+4, valid<=1, `pc`<=`pc`+4.
  - `imemReady` & `stall`: `holdBuf`<=`imemData`, `pc`<=`pc`+4, go HOLD; outputs hold.
  - !`imemReady` & !`stall`: deliver bubble (`NOP_WORD`, valid 0; `programCounterOut` holds).
- HOLD: `imemRead`=0. When `stall` drops, deliver `holdBuf` (PC+4 = current `pc`), go FETCH.
- DISCARD: `imemRead`=1 at old address until `imemReady`; response dropped; then `pc`<=`pendingTarget`, go FETCH. Outputs show bubbles while !`stall`.
- `branchTaken` (highest priority, overrides `stall`): outputs <= NOP_WORD / valid 0 next edge.
  - FETCH with `imemReady`, or HOLD: `pc`<=target, FETCH (response/`holdBuf` dropped).
  - FETCH without `imemReady`: `pendingTarget`<=target, DISCARD.
  - DISCARD: `pendingTarget` overwritten; if `imemReady` same cycle, go FETCH at new target.
- `pc` arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (async assert): `pc`=`RESET_VECTOR`, state FETCH, `imemRead`=0 while `resetN` low, `imemAddr`=`RESET_VECTOR`, `instruction`=`NOP_WORD`, `instructionValid`=0, `programCounterOut`=0, counters 0. Deassertion synchronous to `clk`.
- First edge after reset release: `imemRead`=1 at `RESET_VECTOR`.
- Latency: request accepted at edge N -> instruction on outputs after edge N. Zero-wait memory gives 1 instruction/cycle.
- Stall: outputs and `imemAddr` unchanged each cycle `stall`=1 (except flush on `branchTaken`). At most one word buffered.
- Redirect: first fetch of target issued the cycle after `branchTaken` (FETCH/HOLD), or the cycle after the dropped response (DISCARD). Target word appears no earlier than 2 edges after `branchTaken`.
- Reset mid-DISCARD/HOLD: all pending state cleared, fetch restarts at `RESET_VECTOR`.

## Configuration
- `IF_PERF_COUNT_EN` defined: `fetchCount` increments on each delivered valid instruction; `stallCount` increments each cycle `stall`=1. Both wrap at 2^32, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, zero-wait memory returning addr as data -> valid words 0,4,8,... on consecutive cycles; `programCounterOut` 4,8,12.
- `imemReady` low 3 cycles at 0x10 -> `imemAddr` stable 0x10, 3 bubbles, then word@0x10 with PC+4=0x14.
- `stall` high 4 cycles as response for 0x20 arrives -> `imemRead` low in HOLD, outputs frozen; on release word@0x20 delivered then fetch 0x24.
- `branchTaken`, target 0x103, while fetch of 0x40 outstanding -> 0x40 response dropped, next `imemAddr`=0x100, no valid 0x40 delivered.
- `branchTaken` during `stall` in HOLD -> next edge valid 0, `holdBuf` dropped, fetch 0xFFFF_FFFC then 0x0 (wrap).
- With `IF_PERF_COUNT_EN`: 10 deliveries, 3 stall cycles -> `fetchCount`=10, `stallCount`=3; `resetN` low -> both 0.
